// File: rtl/vram_scheduler.sv
// -----------------------------------------------------------------------------
// vram_scheduler
//
// Write-port scheduler for a 2048-cell text-mode video RAM (32 rows x 64 cols).
// Two requesters (A = console writer, B = effect engine) share the single
// write port under round-robin arbitration. An optional clear engine fills
// every cell with a captured fill code, one cell per cycle.
//
// Optional feature macro: VRAM_SCHED_CLEAR_EN
//   defined   -> clear engine present (clr_start / fill_code / clr_busy live)
//   undefined -> clr_start and fill_code ignored, clr_busy tied to 0,
//                block stays in IDLE arbitration forever
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   a_req/a_addr/a_data   requester A write request, cell address, cell code
//   a_gnt                 one-cycle grant to A (registered)
//   b_req/b_addr/b_data   requester B, same meaning as A
//   b_gnt                 one-cycle grant to B (registered)
//   clr_start, fill_code  clear-screen pulse and the code written by a clear
//   clr_busy              clear in progress (registered)
//   vram_addr/vram_data   video RAM write address / data (registered, held)
//   vram_we               video RAM write enable (registered)
//
// Handshake: a requester raises req with stable addr/data and holds all three
// until it sees its gnt. The write is on the RAM port in the same cycle gnt is
// high. A req sampled while that requester's own gnt is high is not eligible,
// so a requester that keeps req high across its grant is not written twice.
//
// The FSM state is kept in state_q (ST_IDLE / ST_CLEAR) so checkers can bind
// to it directly.
// -----------------------------------------------------------------------------
module vram_scheduler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_req,
  input  logic [10:0] a_addr,
  input  logic [15:0] a_data,
  output logic        a_gnt,
  input  logic        b_req,
  input  logic [10:0] b_addr,
  input  logic [15:0] b_data,
  output logic        b_gnt,
  input  logic        clr_start,
  input  logic [15:0] fill_code,
  output logic        clr_busy,
  output logic [10:0] vram_addr,
  output logic [15:0] vram_data,
  output logic        vram_we
);

  typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        last_b_q, last_b_d;   // 1: B was granted most recently
  logic [10:0] cnt_q, cnt_d;         // clear address counter
  logic [15:0] fill_q, fill_d;       // fill code captured at clear start
  logic        we_d, a_gnt_d, b_gnt_d, busy_d;
  logic [10:0] addr_d;
  logic [15:0] data_d;
  logic        clr_go;
  logic        elig_a, elig_b, pick_a, pick_b;

`ifdef VRAM_SCHED_CLEAR_EN
  assign clr_go = clr_start;
`else
  assign clr_go = 1'b0;
`endif

  // A requester whose grant is showing this cycle is already being served.
  assign elig_a = a_req & ~a_gnt;
  assign elig_b = b_req & ~b_gnt;
  // Lone eligible requester wins outright; on contention the one not granted
  // most recently wins.
  assign pick_a = elig_a & (~elig_b | last_b_q);
  assign pick_b = elig_b & ~pick_a;

  // State register plus registered outputs and datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      last_b_q  <= 1'b1;
      cnt_q     <= '0;
      fill_q    <= '0;
      vram_we   <= 1'b0;
      a_gnt     <= 1'b0;
      b_gnt     <= 1'b0;
      clr_busy  <= 1'b0;
      vram_addr <= '0;
      vram_data <= '0;
    end else begin
      state_q   <= state_d;
      last_b_q  <= last_b_d;
      cnt_q     <= cnt_d;
      fill_q    <= fill_d;
      vram_we   <= we_d;
      a_gnt     <= a_gnt_d;
      b_gnt     <= b_gnt_d;
      clr_busy  <= busy_d;
      vram_addr <= addr_d;
      vram_data <= data_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (clr_go) state_d = ST_CLEAR;
      ST_CLEAR: if (cnt_q == 11'h7FF) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output logic: values the output registers take at the next edge.
  always_comb begin
    we_d     = 1'b0;
    a_gnt_d  = 1'b0;
    b_gnt_d  = 1'b0;
    addr_d   = vram_addr;
    data_d   = vram_data;
    last_b_d = last_b_q;
    cnt_d    = cnt_q;
    fill_d   = fill_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_go) begin
          // Clear wins over any request sampled on the same edge.
          fill_d = fill_code;
          cnt_d  = '0;
        end else if (pick_a) begin
          we_d     = 1'b1;
          a_gnt_d  = 1'b1;
          addr_d   = a_addr;
          data_d   = a_data;
          last_b_d = 1'b0;
        end else if (pick_b) begin
          we_d     = 1'b1;
          b_gnt_d  = 1'b1;
          addr_d   = b_addr;
          data_d   = b_data;
          last_b_d = 1'b1;
        end
      end
      ST_CLEAR: begin
        we_d   = 1'b1;
        addr_d = cnt_q;
        data_d = fill_q;
        cnt_d  = cnt_q + 11'd1;  // wraps to 0 after 2047
      end
      default: ;
    endcase
`ifdef VRAM_SCHED_CLEAR_EN
    // Busy covers the entry cycle through the cycle showing the last write.
    busy_d = (state_d == ST_CLEAR) | (state_q == ST_CLEAR);
`else
    busy_d = 1'b0;
`endif
  end

endmodule

// File: tb/tb_vram_scheduler.sv
module tb_vram_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, b_req, clr_start;
  logic [10:0] a_addr, b_addr;
  logic [15:0] a_data, b_data, fill_code;
  logic        a_gnt, b_gnt, clr_busy, vram_we;
  logic [10:0] vram_addr;
  logic [15:0] vram_data;

  vram_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_req     (a_req),
    .a_addr    (a_addr),
    .a_data    (a_data),
    .a_gnt     (a_gnt),
    .b_req     (b_req),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .b_gnt     (b_gnt),
    .clr_start (clr_start),
    .fill_code (fill_code),
    .clr_busy  (clr_busy),
    .vram_addr (vram_addr),
    .vram_data (vram_data),
    .vram_we   (vram_we)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [29:0] exp_q[$];

  typedef struct {
    logic        a_req;
    logic [10:0] a_addr;
    logic [15:0] a_data;
    logic        b_req;
    logic [10:0] b_addr;
    logic [15:0] b_data;
    logic        e_we;
    logic        e_a_gnt;
    logic        e_b_gnt;
    logic [10:0] e_addr;
    logic [15:0] e_data;
  } vec_t;

  vec_t vecs[11];

  // ---------------- driver / check tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    a_req = 1'b0; a_addr = '0; a_data = '0;
    b_req = 1'b0; b_addr = '0; b_data = '0;
    clr_start = 1'b0; fill_code = '0;
  endtask

  function automatic logic [29:0] outs();
    return {vram_we, a_gnt, b_gnt, vram_addr, vram_data};
  endfunction

  // ---------------- behavioural reference state ----------------
  int          hist[$];      // ids granted so far: 0 = A, 1 = B
  logic        m_a_gnt, m_b_gnt;
  logic [10:0] m_addr;
  logic [15:0] m_data;
  logic        a_pend, b_pend;

  initial begin
    int busy_cycles, writes, bad_wr, bad_gnt, found, stray;
    logic [10:0] exp_addr;

    idle_inputs();
    rst_n = 1'b0;
    #12;
    check("reset_outputs", {clr_busy, outs()}, 31'h0);
    step();
    rst_n = 1'b1;
    step();
    check("post_reset_idle", {clr_busy, outs()}, 31'h0);

    // ---------------- table-driven vectors (from reset) ----------------
    //           a_req addr     data      b_req addr     data      we a  b  addr     data
    vecs[0]  = '{1'b1, 11'h045, 16'h0141, 1'b0, 11'h000, 16'h0000, 1'b1, 1'b1, 1'b0, 11'h045, 16'h0141};
    vecs[1]  = '{1'b0, 11'h000, 16'h0000, 1'b0, 11'h000, 16'h0000, 1'b0, 1'b0, 1'b0, 11'h045, 16'h0141};
    vecs[2]  = '{1'b1, 11'h111, 16'h1111, 1'b1, 11'h222, 16'h2222, 1'b1, 1'b0, 1'b1, 11'h222, 16'h2222};
    vecs[3]  = '{1'b1, 11'h111, 16'h1111, 1'b1, 11'h222, 16'h2222, 1'b1, 1'b1, 1'b0, 11'h111, 16'h1111};
    vecs[4]  = '{1'b1, 11'h111, 16'h1111, 1'b1, 11'h222, 16'h2222, 1'b1, 1'b0, 1'b1, 11'h222, 16'h2222};
    vecs[5]  = '{1'b1, 11'h111, 16'h1111, 1'b1, 11'h222, 16'h2222, 1'b1, 1'b1, 1'b0, 11'h111, 16'h1111};
    vecs[6]  = '{1'b0, 11'h000, 16'h0000, 1'b1, 11'h333, 16'h3333, 1'b1, 1'b0, 1'b1, 11'h333, 16'h3333};
    vecs[7]  = '{1'b0, 11'h000, 16'h0000, 1'b1, 11'h333, 16'h3333, 1'b0, 1'b0, 1'b0, 11'h333, 16'h3333};
    vecs[8]  = '{1'b0, 11'h000, 16'h0000, 1'b1, 11'h344, 16'h4444, 1'b1, 1'b0, 1'b1, 11'h344, 16'h4444};
    vecs[9]  = '{1'b1, 11'h555, 16'h5555, 1'b0, 11'h000, 16'h0000, 1'b1, 1'b1, 1'b0, 11'h555, 16'h5555};
    vecs[10] = '{1'b0, 11'h000, 16'h0000, 1'b0, 11'h000, 16'h0000, 1'b0, 1'b0, 1'b0, 11'h555, 16'h5555};

    for (int i = 0; i < 11; i++) begin
      a_req = vecs[i].a_req; a_addr = vecs[i].a_addr; a_data = vecs[i].a_data;
      b_req = vecs[i].b_req; b_addr = vecs[i].b_addr; b_data = vecs[i].b_data;
      step();
      check($sformatf("vec%0d", i), outs(),
            {vecs[i].e_we, vecs[i].e_a_gnt, vecs[i].e_b_gnt, vecs[i].e_addr, vecs[i].e_data});
    end
    idle_inputs();

`ifdef VRAM_SCHED_CLEAR_EN
    // ---------------- full clear with pending A and late B ----------------
    clr_start = 1'b1; fill_code = 16'h0020;
    a_req = 1'b1; a_addr = 11'h7AA; a_data = 16'h1234;
    step();
    clr_start = 1'b0; fill_code = 16'hFFFF;  // must not disturb the clear
    check("clr_precedence", {clr_busy, vram_we, a_gnt, b_gnt}, 4'b1000);
    busy_cycles = 1; writes = 0; bad_wr = 0; bad_gnt = 0; exp_addr = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 10) begin b_req = 1'b1; b_addr = 11'h2B4; b_data = 16'hBEEF; end
      clr_start = (cyc == 500);
      step();
      if (!clr_busy) break;
      busy_cycles++;
      if (a_gnt || b_gnt) bad_gnt++;
      if (vram_we) begin
        if (vram_addr !== exp_addr || vram_data !== 16'h0020) bad_wr++;
        exp_addr = exp_addr + 11'd1;
        writes++;
      end
    end
    check("clr_busy_cycles", busy_cycles, 2049);
    check("clr_write_count", writes, 2048);
    check("clr_write_content", bad_wr, 0);
    check("clr_no_grants", bad_gnt, 0);
    // First IDLE cycle arbitrates: A was granted last, so B wins first.
    check("post_clr_b_grant", outs(), {1'b1, 1'b0, 1'b1, 11'h2B4, 16'hBEEF});
    b_req = 1'b0;
    step();
    check("post_clr_a_grant", outs(), {1'b1, 1'b1, 1'b0, 11'h7AA, 16'h1234});
    a_req = 1'b0;
    step();
    check("post_clr_idle", {clr_busy, outs()}, {1'b0, 1'b0, 1'b0, 1'b0, 11'h7AA, 16'h1234});
    m_addr = 11'h7AA; m_data = 16'h1234;
`else
    // ---------------- clear engine absent ----------------
    a_req = 1'b1; a_addr = 11'h0AB; a_data = 16'h00CD;
    clr_start = 1'b1; fill_code = 16'h0020;
    step();
    check("noclr_a_grant", {clr_busy, outs()}, {1'b0, 1'b1, 1'b1, 1'b0, 11'h0AB, 16'h00CD});
    a_req = 1'b0;
    stray = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (clr_busy || vram_we) stray++;
    end
    check("noclr_stays_idle", stray, 0);
    clr_start = 1'b0;
    m_addr = 11'h0AB; m_data = 16'h00CD;
`endif

    // ---------------- randomized run against reference model ----------------
    hist.push_back(0);  // A was the last requester granted above
    m_a_gnt = 1'b0; m_b_gnt = 1'b0;
    a_pend = 1'b0; b_pend = 1'b0;
    for (int c = 0; c < 400; c++) begin
      int  w;
      bit  ea, eb;
      if (!a_pend && $urandom_range(0, 2) == 0) begin
        a_pend = 1'b1; a_addr = 11'($urandom_range(0, 2047)); a_data = 16'($urandom);
      end
      if (!b_pend && $urandom_range(0, 2) == 0) begin
        b_pend = 1'b1; b_addr = 11'($urandom_range(0, 2047)); b_data = 16'($urandom);
      end
      a_req = a_pend; b_req = b_pend;
      ea = a_req && !m_a_gnt;
      eb = b_req && !m_b_gnt;
      if (ea && eb) w = (hist[$] == 1) ? 0 : 1;
      else if (ea)  w = 0;
      else if (eb)  w = 1;
      else          w = -1;
      if (w == 0)      begin m_addr = a_addr; m_data = a_data; end
      else if (w == 1) begin m_addr = b_addr; m_data = b_data; end
      m_a_gnt = (w == 0);
      m_b_gnt = (w == 1);
      exp_q.push_back({w != -1, m_a_gnt, m_b_gnt, m_addr, m_data});
      if (w != -1) hist.push_back(w);
      step();
      check("rand_cycle", {clr_busy, outs()}, {1'b0, exp_q.pop_front()});
      // Requesters react to the grant they see; half re-request at once.
      if (a_gnt) begin
        a_pend = 1'b0;
        if ($urandom_range(0, 1) == 1) begin
          a_pend = 1'b1; a_addr = 11'($urandom_range(0, 2047)); a_data = 16'($urandom);
        end
      end
      if (b_gnt) begin
        b_pend = 1'b0;
        if ($urandom_range(0, 1) == 1) begin
          b_pend = 1'b1; b_addr = 11'($urandom_range(0, 2047)); b_data = 16'($urandom);
        end
      end
    end
    idle_inputs();
    step();
    step();

`ifdef VRAM_SCHED_CLEAR_EN
    // ---------------- reset in the middle of a clear ----------------
    clr_start = 1'b1; fill_code = 16'h5A5A;
    step();
    clr_start = 1'b0;
    found = 0;
    for (int c = 0; c < 3000; c++) begin
      step();
      if (vram_we && vram_addr == 11'h300) begin found = 1; break; end
    end
    check("clr_reached_0x300", found, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midclr_reset", {clr_busy, outs()}, 31'h0);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (vram_we || clr_busy) stray++;
    end
    check("midclr_no_writes", stray, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_scheduler.md
VRAM_SCHEDULER -- requirements
Module: vram_scheduler

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all other ports SHALL be as follows:
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 a_req  in  1  requester A (console writer) write request.
REQ-005 a_addr  in  11  A cell address {row[4:0], col[5:0]}.
REQ-006 a_data  in  16  A cell code: [7:0] char, [8] invert, [9] blink.
REQ-007 a_gnt  out  1  one-cycle grant to A.
REQ-008 b_req, b_addr, b_data, b_gnt  same widths and meaning as A, for requester B (effect engine).
REQ-009 clr_start  in  1  clear-screen request pulse.
REQ-010 fill_code  in  16  cell code written by a clear.
REQ-011 clr_busy  out  1  clear in progress.
REQ-012 vram_addr  out  11  video RAM write-port address.
REQ-013 vram_data  out  16  video RAM write-port data.
REQ-014 vram_we  out  1  video RAM write enable.

Function
REQ-015 States SHALL be IDLE and CLEAR; at most one video RAM write SHALL issue per cycle.
REQ-016 In IDLE, requests SHALL be sampled at edge N; the winner's addr/data SHALL appear on vram_addr/vram_data with vram_we=1 and its gnt=1 during cycle N+1 (latency 1, all outputs registered).
REQ-017 A requester SHALL hold req, addr and data stable until it sees gnt; a req sampled while that requester's own gnt is high SHALL be ignored (no double write).
REQ-018 Contention SHALL be resolved round-robin: the requester not granted most recently wins; after reset A wins first.
REQ-019 A lone eligible requester SHALL win regardless of the round-robin pointer; A and B alternating SHALL achieve back-to-back writes.
REQ-020 When no grant issues, vram_we, a_gnt and b_gnt SHALL be 0; vram_addr/vram_data SHALL hold their last values.
REQ-021 clr_start sampled high in IDLE SHALL capture fill_code, enter CLEAR and raise clr_busy from the next cycle; clr_start SHALL take precedence over a simultaneous a_req/b_req, which SHALL receive no grant that cycle.
REQ-022 In CLEAR, an 11-bit counter SHALL write fill_code to addresses 0,1,...,2047, one per cycle with vram_we=1, 2048 consecutive writes.
REQ-023 After the write to address 2047, the state SHALL return to IDLE and clr_busy SHALL fall on the following cycle; the counter SHALL wrap to 0.
REQ-024 clr_start during CLEAR SHALL be ignored; a_req/b_req SHALL stay pending, ungranted, and be arbitrated normally from the first IDLE cycle.
REQ-025 Changes to fill_code during CLEAR SHALL NOT affect the clear in progress.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, clr_busy=0, vram_we=0, a_gnt=0, b_gnt=0, vram_addr=0, vram_data=0, counter=0, pointer "B last", captured fill code=0.
REQ-027 Reset asserted mid-CLEAR SHALL abandon the clear; no write SHALL issue until a new request after rst_n rises.

Configuration
REQ-028 Macro VRAM_SCHED_CLEAR_EN defined: clear engine SHALL be present per REQ-021..REQ-025.
REQ-029 Macro VRAM_SCHED_CLEAR_EN undefined: clr_start and fill_code SHALL be ignored, clr_busy SHALL be constant 0, and the block SHALL remain permanently in IDLE arbitration.

Verification
REQ-030 After reset, a_req=1, a_addr=0x045, a_data=0x0141 at edge N -> cycle N+1: vram_we=1, vram_addr=0x045, vram_data=0x0141, a_gnt=1; b_gnt=0.
REQ-031 a_req and b_req both held high continuously -> grants alternate A,B,A,B with vram_we=1 every cycle; no requester is granted twice in a row.
REQ-032 clr_start pulse with fill_code=0x0020 -> clr_busy=1 for 2049 cycles, exactly 2048 writes of 0x0020 to addresses 0..2047 in order, then clr_busy=0.
REQ-033 b_req raised 10 cycles into a clear -> b_gnt=0 throughout the clear; b granted in the cycle after the first IDLE cycle, with the correct b_addr/b_data.
REQ-034 rst_n pulsed low at clear address 0x300 -> clr_busy=0 and vram_we=0 immediately; no further writes without new requests.
REQ-035 Build without VRAM_SCHED_CLEAR_EN, pulse clr_start with a_req high -> clr_busy stays 0 and A is granted at N+1.
